// File: rtl/mdio_master_arb.sv
// rtl/mdio_master_arb.sv - Round-robin shared Clause-22 MDIO master; define MDIO_TA_CHECK_EN to add ack_err.
module mdio_master_arb #(
    parameter int NUM_REQ      = 4,
    parameter int MDC_DIV      = 25,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic                       axi_aclk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [5*NUM_REQ-1:0]       req_phy_addr,
    input  logic [5*NUM_REQ-1:0]       req_reg_addr,
    input  logic [16*NUM_REQ-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]         ack,
    output logic [15:0]                rdata,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
`ifdef MDIO_TA_CHECK_EN
    output logic                       ack_err,
`endif
    output logic                       phy_mdc,
    output logic                       phy_mdio_o,
    output logic                       phy_mdio_t,
    input  logic                       phy_mdio_i
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int DW = $clog2(MDC_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(MDC_DIV - 1);
    localparam logic [5:0] PRE_LAST = 6'((PREAMBLE_LEN == 0) ? 0 : PREAMBLE_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRE   = 2'd1;
    localparam logic [1:0] S_FRAME = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [DW-1:0]      r_div;
    logic               r_mdc;
    logic [5:0]         r_cnt;
    logic [31:0]        r_shift;
    logic               r_we;
    logic [15:0]        r_rx;
    logic [15:0]        r_rdata;
    logic               r_busy;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      r_last;
    logic [NUM_REQ-1:0] r_ack;
`ifdef MDIO_TA_CHECK_EN
    logic               r_ta_err;
    logic               r_ack_err;
`endif

    logic               w_found;
    logic [GW-1:0]      w_sel;
    int                 w_idx;
    logic               w_rel;

    // First requesting index above the last grant, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int c;
            c = int'(r_last) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (req[GW'(c)]) begin
                w_found = 1'b1;
                w_sel   = GW'(c);
                w_idx   = c;
            end
        end
    end

    // Turnaround and data of a read are owned by the PHY.
    assign w_rel      = (r_state == S_FRAME) && !r_we && (r_cnt >= 6'd14);
    assign phy_mdio_t = !((r_state == S_PRE) || ((r_state == S_FRAME) && !w_rel));
    assign phy_mdio_o = ((r_state == S_FRAME) && !w_rel) ? r_shift[31] : 1'b1;
    assign phy_mdc    = r_mdc;
    assign ack        = r_ack;
    assign rdata      = r_rdata;
    assign busy       = r_busy;
    assign grant_id   = r_grant;
`ifdef MDIO_TA_CHECK_EN
    assign ack_err    = r_ack_err;
`endif

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_mdc     <= 1'b0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_we      <= 1'b0;
            r_rx      <= '0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
            r_grant   <= '0;
            r_last    <= GW'(NUM_REQ - 1);
            r_ack     <= '0;
`ifdef MDIO_TA_CHECK_EN
            r_ta_err  <= 1'b0;
            r_ack_err <= 1'b0;
`endif
        end else begin
            r_ack <= '0;
`ifdef MDIO_TA_CHECK_EN
            r_ack_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel;
                        r_last  <= w_sel;
                        r_we    <= req_we[w_sel];
                        r_shift <= {2'b01, (req_we[w_sel] ? 2'b01 : 2'b10),
                                    req_phy_addr[5*w_idx +: 5], req_reg_addr[5*w_idx +: 5],
                                    (req_we[w_sel] ? {2'b10, req_wdata[16*w_idx +: 16]} : 18'h0)};
                        r_busy  <= 1'b1;
                        r_div   <= '0;
                        r_mdc   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= (PREAMBLE_LEN == 0) ? S_FRAME : S_PRE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        r_mdc <= ~r_mdc;
                        if (!r_mdc) begin
                            if ((r_state == S_FRAME) && !r_we) begin
                                if (r_cnt >= 6'd16) r_rx <= {r_rx[14:0], phy_mdio_i};
`ifdef MDIO_TA_CHECK_EN
                                if (r_cnt == 6'd15) r_ta_err <= phy_mdio_i;
`endif
                            end
                        end else if (r_state == S_PRE) begin
                            if (r_cnt == PRE_LAST) begin
                                r_state <= S_FRAME;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else if (r_cnt == 6'd31) begin
                            r_state        <= S_DONE;
                            r_busy         <= 1'b0;
                            r_ack[r_grant] <= 1'b1;
`ifdef MDIO_TA_CHECK_EN
                            if (!r_we) begin
                                r_rdata   <= r_ta_err ? 16'hFFFF : r_rx;
                                r_ack_err <= r_ta_err;
                            end
`else
                            if (!r_we) r_rdata <= r_rx;
`endif
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_shift <= {r_shift[30:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

endmodule
